// File: rtl/puf_uart_pkg.sv
// Shared types and constants for the PUF response UART transmitter.
package puf_uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StAck,
    StWaitClr
  } tx_state_t;

endpackage

// File: rtl/baud_counter.sv
// Down-counting bit timer: bit_end marks the last clock of each UART bit period.
module baud_counter
  import puf_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // load parks the counter at the reload value so the first bit gets a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (load || (cnt_q == '0)) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/response_uart_tx.sv
// Sends one buffered response byte over UART, then pulses ack_reset to clear the buffer.
module response_uart_tx
  import puf_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned ACK_CYCLES   = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ready_to_read,
  input  logic [UART_DATA_BITS-1:0] data_in,
  output logic                      tx,
  output logic                      busy,
  output logic                      ack_reset,
  output logic                      tx_done
);

  localparam logic [2:0] BitLast  = 3'(UART_DATA_BITS - 1);
  localparam logic       StopLast = 1'(STOP_BITS - 1);
  localparam logic [3:0] AckLast  = 4'(ACK_CYCLES - 1);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic [3:0]                ack_cnt_q, ack_cnt_d;
  logic                      tx_q, tx_d;
  logic                      ack_reset_q, ack_reset_d;
  logic                      tx_done_q, tx_done_d;
  logic                      baud_load;
  logic                      bit_end;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (baud_load),
    .bit_end (bit_end)
  );

  // Outputs are registered from the current state, so the line lags the state by one clock.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    tx_d        = 1'b1;
    ack_reset_d = 1'b0;
    tx_done_d   = 1'b0;
    baud_load   = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_load = 1'b1;
        if (ready_to_read) begin
          shift_d = data_in;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BitLast) begin
            bit_idx_d = '0;
            state_d   = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_cnt_q == StopLast) begin
            stop_cnt_d = 1'b0;
            tx_done_d  = 1'b1;
            state_d    = StAck;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      StAck: begin
        baud_load   = 1'b1;
        ack_reset_d = 1'b1;
        if (ack_cnt_q == AckLast) begin
          ack_cnt_d = '0;
          state_d   = StWaitClr;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      StWaitClr: begin
        // Holding here until the buffer drops its flag keeps a byte from being sent twice.
        baud_load = 1'b1;
        if (!ready_to_read) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      ack_cnt_q   <= '0;
      tx_q        <= 1'b1;
      ack_reset_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      tx_q        <= tx_d;
      ack_reset_q <= ack_reset_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx        = tx_q;
  assign ack_reset = ack_reset_q;
  assign tx_done   = tx_done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_response_uart_tx.sv
// Randomized self-checking bench: frame waveform model versus two parameterizations of the DUT.
module tb_response_uart_tx;

  localparam int C1 = 4;
  localparam int S1 = 1;
  localparam int A1 = 2;
  localparam int C2 = 2;
  localparam int S2 = 2;
  localparam int A2 = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ready = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] data = 8'h00;

  logic rdy1, rdy2;
  logic tx1, busy1, ack1, done1;
  logic tx2, busy2, ack2, done2;
  logic tx_m, busy_m, ack_m, done_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  assign rdy1   = sel ? 1'b0 : ready;
  assign rdy2   = sel ? ready : 1'b0;
  assign tx_m   = sel ? tx2 : tx1;
  assign busy_m = sel ? busy2 : busy1;
  assign ack_m  = sel ? ack2 : ack1;
  assign done_m = sel ? done2 : done1;

  response_uart_tx #(
    .CLKS_PER_BIT(C1),
    .STOP_BITS   (S1),
    .ACK_CYCLES  (A1)
  ) dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready_to_read(rdy1),
    .data_in      (data),
    .tx           (tx1),
    .busy         (busy1),
    .ack_reset    (ack1),
    .tx_done      (done1)
  );

  response_uart_tx #(
    .CLKS_PER_BIT(C2),
    .STOP_BITS   (S2),
    .ACK_CYCLES  (A2)
  ) dut2 (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready_to_read(rdy2),
    .data_in      (data),
    .tx           (tx2),
    .busy         (busy2),
    .ack_reset    (ack2),
    .tx_done      (done2)
  );

  // Expected line level j clocks after the capture edge: start, 8 data LSB first, stop bits.
  function automatic logic exp_tx(input int j, input logic [7:0] d, input int c, input int s);
    int b;
    if (j < 1 || j > (9 + s) * c) return 1'b1;
    b = (j - 1) / c;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Sends one byte on the selected DUT and checks every cycle until it is idle again.
  task automatic run_frame(input logic [7:0] d, input int drop_j, input int chg_j,
                           input logic [7:0] d2, input string tag);
    int c, s, a, len, idle_j, b;
    logic [7:0] rx;
    c = sel ? C2 : C1;
    s = sel ? S2 : S1;
    a = sel ? A2 : A1;
    len = (9 + s) * c;
    idle_j = ((len + a > drop_j) ? len + a : drop_j) + 1;
    rx = 8'h00;
    data = d;
    ready = 1'b1;
    @(posedge clock);
    for (int j = 0; j <= idle_j + 2; j++) begin
      @(negedge clock);
      n_tests++;
      if (tx_m !== exp_tx(j, d, c, s)) begin
        n_fail++;
        $display("FAIL %s tx j=%0d got %b want %b", tag, j, tx_m, exp_tx(j, d, c, s));
      end
      n_tests++;
      if (done_m !== (j == len)) begin
        n_fail++;
        $display("FAIL %s tx_done j=%0d got %b want %b", tag, j, done_m, (j == len));
      end
      n_tests++;
      if (ack_m !== (j > len && j <= len + a)) begin
        n_fail++;
        $display("FAIL %s ack_reset j=%0d got %b want %b", tag, j, ack_m,
                 (j > len && j <= len + a));
      end
      n_tests++;
      if (busy_m !== (j < idle_j)) begin
        n_fail++;
        $display("FAIL %s busy j=%0d got %b want %b", tag, j, busy_m, (j < idle_j));
      end
      if (j >= c + 1 && j <= 9 * c && ((j - 1) % c) == c / 2) begin
        b = (j - 1) / c;
        rx[b-1] = tx_m;
      end
      if (j == chg_j) data = d2;
      if (j == drop_j) ready = 1'b0;
    end
    n_tests++;
    if (rx !== d) begin
      n_fail++;
      $display("FAIL %s decode got %h want %h", tag, rx, d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ready = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({tx1, busy1, ack1, done1, tx2, busy2, ack2, done2} !== 8'b1000_1000) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 10001000",
               {tx1, busy1, ack1, done1, tx2, busy2, ack2, done2});
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    n_tests++;
    if ({tx1, busy1, tx2, busy2} !== 4'b1010) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b want 1010", {tx1, busy1, tx2, busy2});
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_frame(8'hA5, (9 + S1) * C1 + 2, -1, 8'h00, "basic_a5");
  endtask

  task automatic test_held_level();
    sel = 1'b0;
    run_frame(8'h5A, (9 + S1) * C1 + A1 + 200, -1, 8'h00, "held_level");
  endtask

  task automatic test_data_change();
    sel = 1'b0;
    run_frame(8'h3C, (9 + S1) * C1 + 2, 1 + 3 * C1, 8'hFF, "data_change");
  endtask

  task automatic test_reset_mid_frame();
    int rj;
    sel = 1'b0;
    rj = 1 + 5 * C1 + 1;
    data = 8'hC3;
    ready = 1'b1;
    @(posedge clock);
    for (int j = 0; j < rj; j++) @(negedge clock);
    reset_n = 1'b0;
    ready = 1'b0;
    #1;
    n_tests++;
    if ({tx1, busy1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_mid_frame_async got tx,busy=%b want 10", {tx1, busy1});
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      n_tests++;
      if ({tx1, busy1, ack1, done1} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_mid_frame_hold got %b want 1000", {tx1, busy1, ack1, done1});
      end
    end
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      n_tests++;
      if ({tx1, busy1, ack1} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_mid_frame_release got %b want 100", {tx1, busy1, ack1});
      end
    end
    run_frame(8'h96, (9 + S1) * C1 + 2, -1, 8'h00, "after_reset");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_frame(8'h7E, (9 + S1) * C1 + 2, -1, 8'h00, "b2b_first");
    repeat (2) @(negedge clock);
    run_frame(8'h81, (9 + S1) * C1 + 2, -1, 8'h00, "b2b_second");
  endtask

  task automatic test_param_sweep();
    sel = 1'b1;
    run_frame(8'hB4, (9 + S2) * C2 + 2, -1, 8'h00, "sweep_b4");
    run_frame(8'h01, (9 + S2) * C2 + A2 + 3, -1, 8'h00, "sweep_01");
    sel = 1'b0;
  endtask

  task automatic test_random();
    int len;
    logic [7:0] d, d2;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      len = sel ? (9 + S2) * C2 : (9 + S1) * C1;
      d = 8'($urandom);
      d2 = 8'($urandom);
      run_frame(d, len + 1 + int'($urandom_range(0, 6)), int'($urandom_range(1, len)), d2,
                "random");
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_level();
    test_data_change();
    test_reset_mid_frame();
    test_back_to_back();
    test_param_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/response_uart_tx.md
RESPONSE_UART_TX -- requirements
Module: response_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1, meaning number of stop bits per frame; legal values 1 or 2.
REQ-003 Parameter ACK_CYCLES, default 2, meaning width in clocks of the ack_reset pulse; legal range 1..15.
REQ-004 clock  input  1  sole clock, rising-edge active.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 ready_to_read  input  1  level from the response buffer; high means an 8-bit response is complete.
REQ-007 data_in  input  8  response byte from the buffer; valid while ready_to_read is high.
REQ-008 tx  output  1  UART serial line to the host; idle high.
REQ-009 busy  output  1  high from byte capture until return to IDLE.
REQ-010 ack_reset  output  1  pulse that clears the response buffer (drives its computer_ack_reset).
REQ-011 tx_done  output  1  one-cycle pulse on the final stop-bit cycle.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, ACK, WAIT_CLR, all registered.
REQ-013 IDLE: when ready_to_read is sampled high at edge k, the block SHALL latch data_in into an 8-bit shift register and enter START; tx SHALL be low from edge k+1.
REQ-014 START SHALL hold tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL send 8 bits LSB first, each held for CLKS_PER_BIT cycles; a 3-bit bit index SHALL count 0..7 and then enter STOP.
REQ-016 STOP SHALL hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done SHALL pulse high on its final cycle; the next state SHALL be ACK.
REQ-017 ACK SHALL hold ack_reset=1 for exactly ACK_CYCLES cycles, then enter WAIT_CLR.
REQ-018 WAIT_CLR SHALL hold ack_reset=0 and return to IDLE on the first cycle ready_to_read is sampled low; a byte is therefore never sent twice.
REQ-019 A change to ready_to_read or data_in in any state other than IDLE SHALL be ignored; the latched byte is sent unchanged.
REQ-020 The baud counter SHALL count down from CLKS_PER_BIT-1 to 0 and reload on each bit boundary; it SHALL be sized with $clog2(CLKS_PER_BIT) bits and SHALL NOT wrap mid-bit.
REQ-021 busy SHALL be low only in IDLE.
REQ-022 tx, ack_reset and tx_done SHALL be driven from flops, with no combinational path from any input.
REQ-023 Frame length from capture to the end of the stop bit SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.

Reset
REQ-024 While reset_n is low: state=IDLE, tx=1, busy=0, ack_reset=0, tx_done=0, counters=0, shift register=0.
REQ-025 A reset asserted mid-frame SHALL force tx high immediately (asynchronous) and SHALL NOT produce an ack_reset pulse.
REQ-026 Reset deassertion is synchronized externally; after release the block SHALL wait in IDLE for ready_to_read.

Structure
REQ-027 Package puf_uart_pkg SHALL hold the tx_state_t enum, DEFAULT_CLKS_PER_BIT=104 and UART_DATA_BITS=8.
REQ-028 Sub-module baud_counter SHALL own the reload/terminal-count logic: inputs clock, reset_n, load; output bit_end.
REQ-029 The top level SHALL contain the FSM, shift register, bit index, stop-bit counter and ACK counter.

Verification (CLKS_PER_BIT=4, STOP_BITS=1, ACK_CYCLES=2)
REQ-030 Basic frame: data_in=0xA5, ready_to_read high -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done on cycle 40; ack_reset high for 2 cycles.
REQ-031 Held level: ready_to_read held high for 200 cycles after the ack pulse -> exactly one frame, busy stays high in WAIT_CLR, no second start bit.
REQ-032 Data change: data_in changes 0x3C->0xFF during DATA -> the serial bits still decode as 0x3C.
REQ-033 Reset mid-frame: reset_n low during bit 4 -> tx=1 and busy=0 in the same cycle, no ack_reset, a new frame is sent on the next ready_to_read.
REQ-034 Back-to-back: ready_to_read drops one cycle after ack_reset and rises again 5 cycles later with 0x81 -> a second frame decodes as 0x81, with a start-bit gap of at least 1 idle cycle.
REQ-035 Parameter sweep: STOP_BITS=2, CLKS_PER_BIT=2 -> stop high for 4 cycles, frame 22 cycles, tx_done aligned to the last stop cycle.
